mcpu_pll_seq: RTL

PLL reset/lock sequencer for the MCPU clocking front end. It runs on the free-running 125 MHz board clock. It drives the PLL's reset, qualifies the PLL's `locked` flag, and holds the system reset until lock has been stable for a programmable interval. Lock timeouts are retried a bounded number of times before a latched fault is declared.

---
 rtl/mcpu_clk_pkg.sv | 35 +++
 rtl/mcpu_sync2.sv | 25 ++
 rtl/mcpu_pll_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mcpu_clk_pkg.sv
// Shared definitions for the MCPU clocking front end: PLL sequencer state
// encoding, parameter defaults and small elaboration-time helpers.
package mcpu_clk_pkg;

    // Sequencer states, in bring-up order.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_t;

    // Defaults for the 125 MHz board clock.
    localparam int unsigned PLL_RST_CYCLES_DEF    = 16;
    localparam int unsigned PLL_LOCK_TIMEOUT_DEF  = 65536;
    localparam int unsigned PLL_STABLE_CYCLES_DEF = 1024;
    localparam int unsigned PLL_MAX_RETRIES_DEF   = 3;

    // Largest of three interval lengths; sizes the shared counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Counter width able to hold values up to (len - 1); never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/mcpu_sync2.sv
// Two-flop synchronizer for asynchronous level inputs. Both stages clear to 0
// on the synchronous reset so consumers see a known-inactive value.
module mcpu_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a cycle to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mcpu_pll_seq.sv
// PLL reset/lock sequencer. Pulses the PLL reset, waits for a synchronized
// lock that stays up for STABLE_CYCLES, then releases the system reset.
// Lock timeouts re-reset the PLL up to MAX_RETRIES times before a latched FAULT.
// Build option: MCPU_PLL_SEQ_RELOCK_EN -- when defined, lock loss in RUN
// re-resets the PLL; otherwise it only reasserts sys_rst and waits for relock.
module mcpu_pll_seq
    import mcpu_clk_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = PLL_RST_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT  = PLL_LOCK_TIMEOUT_DEF,
    parameter int unsigned STABLE_CYCLES = PLL_STABLE_CYCLES_DEF,
    parameter int unsigned MAX_RETRIES   = PLL_MAX_RETRIES_DEF
) (
    input  logic                               clk125,
    input  logic                               rst,
    input  logic                               locked,
    input  logic                               relock_req,
    output logic                               pll_rst,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retries
);

    localparam int unsigned CNT_W   = cnt_width(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    // Terminal counts: the counter starts at 0 on state entry, so an interval
    // of N cycles ends when the counter shows N-1.
    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

`ifdef MCPU_PLL_SEQ_RELOCK_EN
    localparam pll_seq_state_t LOSS_STATE = RESET_PLL;
`else
    localparam pll_seq_state_t LOSS_STATE = WAIT_LOCK;
`endif

    pll_seq_state_t      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RETRY_W-1:0]  retries_q, retries_d;
    logic                locked_s;

    mcpu_sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk125),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // State, interval counter and retry count registers.
    always_ff @(posedge clk125) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retries_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
        end
    end

    // Next-state, counter and retry logic.
    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        cnt_d     = cnt_q + CNT_W'(1);

        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end

            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing in the same cycle.
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retries_q == RETRY_LIMIT) begin
                        state_d = FAULT;
                    end else begin
                        retries_d = retries_q + RETRY_W'(1);
                        state_d   = RESET_PLL;
                    end
                end
            end

            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = RUN;
                    retries_d = '0;
                end
            end

            RUN: begin
                // No interval to time here; hold the counter.
                cnt_d = cnt_q;
                if (relock_req) begin
                    state_d = RESET_PLL;
                end else if (!locked_s) begin
                    state_d = LOSS_STATE;
                end
            end

            FAULT: begin
                cnt_d = cnt_q;
            end

            default: begin
                state_d = RESET_PLL;
            end
        endcase

        // Every transition starts the next interval from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        pll_rst = 1'b1;
        sys_rst = 1'b1;
        ready   = 1'b0;
        fault   = 1'b0;

        unique case (state_q)
            RESET_PLL: begin
                pll_rst = 1'b1;
            end
            WAIT_LOCK, STABLE: begin
                pll_rst = 1'b0;
            end
            RUN: begin
                pll_rst = 1'b0;
                sys_rst = 1'b0;
                ready   = 1'b1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                pll_rst = 1'b1;
            end
        endcase
    end

    assign retries = retries_q;

endmodule
